// File: rtl/apb_pkg.sv
// Shared types and constants for the AXI4-Lite to APB-style bridge.
package apb_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DECODE = 3'd1,
        REQ    = 3'd2,
        BRESP  = 3'd3,
        RRESP  = 3'd4
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [3:0] PERIPH_MIN = 4'h2;
    localparam logic [3:0] PERIPH_MAX = 4'h7;

    function automatic logic periph_hit(input logic [11:0] addr);
        return (addr[11:8] >= PERIPH_MIN) && (addr[11:8] <= PERIPH_MAX);
    endfunction

endpackage

// File: rtl/apb_timeout_cnt.sv
// Counts REQ cycles; cnt holds the ordinal of the current cycle, so expired
// rises in cycle number TIMEOUT when no completion has been seen.
module apb_timeout_cnt #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT + 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= W'(1);
        end else if (en && !expired) begin
            cnt <= cnt + W'(1);
        end
    end

    assign expired = en && (cnt == W'(TIMEOUT));

endmodule

// File: rtl/axi2apb_bridge.sv
// AXI4-Lite slave to simple downstream request bridge, one transaction at a time.
// States: IDLE accept AW/W/AR | DECODE range check | REQ sel high | BRESP/RRESP respond
module axi2apb_bridge
    import apb_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] s_awaddr,
    input  logic        s_awvalid,
    output logic        s_awready,
    input  logic [31:0] s_wdata,
    input  logic        s_wvalid,
    output logic        s_wready,
    output logic [1:0]  s_bresp,
    output logic        s_bvalid,
    input  logic        s_bready,
    input  logic [31:0] s_araddr,
    input  logic        s_arvalid,
    output logic        s_arready,
    output logic [31:0] s_rdata,
    output logic [1:0]  s_rresp,
    output logic        s_rvalid,
    input  logic        s_rready,
    output logic        sel,
    output logic        wr_out,
    output logic [11:0] addr_out,
    output logic [31:0] data_out,
    input  logic        ready,
    input  logic [31:0] rdata_in,
    input  logic        err_in
);

    state_t      state, state_nxt;
    logic        run;
    logic        aw_v, w_v, ar_v;
    logic [11:0] aw_addr, ar_addr;
    logic [31:0] w_data;
    logic        cur_wr;
    logic [11:0] cur_addr;
    logic [31:0] cur_data;
    logic [1:0]  resp_q;
    logic [31:0] rdata_q;
    logic        last_grant;
    logic        wr_pend, rd_pend, pick_wr, timeout;
    logic        unused_addr_hi;

    assign unused_addr_hi = ^{s_awaddr[31:12], s_araddr[31:12]};

    assign wr_pend = aw_v && w_v;
    assign rd_pend = ar_v;
    // last_grant=1 means write won the last contested cycle, so read goes next.
    assign pick_wr = wr_pend && (!rd_pend || !last_grant);

    assign s_awready = run && (state == IDLE) && !aw_v;
    assign s_wready  = run && (state == IDLE) && !w_v;
    assign s_arready = run && (state == IDLE) && !ar_v;

    apb_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_tmo (
        .clk     (clk),
        .rst     (rst),
        .clr     (state != REQ),
        .en      (state == REQ),
        .expired (timeout)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (wr_pend || rd_pend) state_nxt = DECODE;
            DECODE:  if (periph_hit(cur_addr)) state_nxt = REQ;
                     else state_nxt = cur_wr ? BRESP : RRESP;
            REQ:     if (ready || timeout) state_nxt = cur_wr ? BRESP : RRESP;
            BRESP:   if (s_bready) state_nxt = IDLE;
            RRESP:   if (s_rready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run        <= 1'b0;
            aw_v       <= 1'b0;
            w_v        <= 1'b0;
            ar_v       <= 1'b0;
            aw_addr    <= '0;
            ar_addr    <= '0;
            w_data     <= '0;
            cur_wr     <= 1'b0;
            cur_addr   <= '0;
            cur_data   <= '0;
            resp_q     <= RESP_OKAY;
            rdata_q    <= '0;
            last_grant <= 1'b0;
        end else begin
            run <= 1'b1;
            if (s_awvalid && s_awready) begin
                aw_v    <= 1'b1;
                aw_addr <= s_awaddr[11:0];
            end
            if (s_wvalid && s_wready) begin
                w_v    <= 1'b1;
                w_data <= s_wdata;
            end
            if (s_arvalid && s_arready) begin
                ar_v    <= 1'b1;
                ar_addr <= s_araddr[11:0];
            end
            case (state)
                IDLE: if (wr_pend || rd_pend) begin
                    cur_wr <= pick_wr;
                    if (pick_wr) begin
                        cur_addr <= aw_addr;
                        cur_data <= w_data;
                        aw_v     <= 1'b0;
                        w_v      <= 1'b0;
                    end else begin
                        cur_addr <= ar_addr;
                        cur_data <= '0;
                        ar_v     <= 1'b0;
                    end
                    if (wr_pend && rd_pend) last_grant <= pick_wr;
                end
                DECODE: if (!periph_hit(cur_addr)) begin
                    resp_q  <= RESP_DECERR;
                    rdata_q <= '0;
                end
                REQ: if (ready) begin
                    resp_q  <= err_in ? RESP_SLVERR : RESP_OKAY;
                    rdata_q <= cur_wr ? 32'd0 : rdata_in;
                end else if (timeout) begin
                    resp_q  <= RESP_SLVERR;
                    rdata_q <= '0;
                end
                default: ;
            endcase
        end
    end

    assign sel      = (state == REQ);
    assign wr_out   = cur_wr;
    assign addr_out = cur_addr;
    assign data_out = cur_data;
    assign s_bvalid = (state == BRESP);
    assign s_bresp  = resp_q;
    assign s_rvalid = (state == RRESP);
    assign s_rresp  = resp_q;
    assign s_rdata  = rdata_q;

endmodule

// File: tb/tb_axi2apb_bridge.sv
// Directed bench for axi2apb_bridge: hand-computed expectations, immediate assertions.
module tb_axi2apb_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata, rdata_in, data_out;
    logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic        s_arvalid, s_arready, s_rvalid, s_rready;
    logic [1:0]  s_bresp, s_rresp;
    logic        sel, wr_out, ready, err_in;
    logic [11:0] addr_out;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    axi2apb_bridge dut (
        .clk       (clk),
        .rst       (rst),
        .s_awaddr  (s_awaddr),
        .s_awvalid (s_awvalid),
        .s_awready (s_awready),
        .s_wdata   (s_wdata),
        .s_wvalid  (s_wvalid),
        .s_wready  (s_wready),
        .s_bresp   (s_bresp),
        .s_bvalid  (s_bvalid),
        .s_bready  (s_bready),
        .s_araddr  (s_araddr),
        .s_arvalid (s_arvalid),
        .s_arready (s_arready),
        .s_rdata   (s_rdata),
        .s_rresp   (s_rresp),
        .s_rvalid  (s_rvalid),
        .s_rready  (s_rready),
        .sel       (sel),
        .wr_out    (wr_out),
        .addr_out  (addr_out),
        .data_out  (data_out),
        .ready     (ready),
        .rdata_in  (rdata_in),
        .err_in    (err_in)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic do_w, input logic [31:0] wa, input logic [31:0] wd,
                         input logic do_r, input logic [31:0] ra);
        int n = 0;
        @(negedge clk);
        s_awvalid = do_w; s_awaddr = wa; s_wvalid = do_w; s_wdata = wd;
        s_arvalid = do_r; s_araddr = ra;
        while (!((!do_w || (s_awready && s_wready)) && (!do_r || s_arready)) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("handshake", 32'(n < 50), 32'd1);
        @(posedge clk);
        #1;
        s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
    endtask

    task automatic serve(input int dly, input logic [31:0] rd, input logic er,
                         output logic w, output logic [11:0] a, output logic [31:0] d,
                         output int cyc);
        int n = 0;
        cyc = 0;
        @(negedge clk);
        while (!sel && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (sel) cyc = 1;
        w = wr_out; a = addr_out; d = data_out;
        repeat (dly) begin
            @(negedge clk);
            if (sel) cyc++;
        end
        ready = 1'b1; rdata_in = rd; err_in = er;
        @(posedge clk);
        #1;
        ready = 1'b0; rdata_in = '0; err_in = 1'b0;
        @(negedge clk);
        if (sel) cyc++;
    endtask

    task automatic get_b(input string tag, output logic [1:0] resp);
        int n = 0;
        while (!s_bvalid && n < 50) begin
            @(negedge clk);
            n++;
        end
        resp = s_bresp;
        @(negedge clk);
        chk({tag, "_bhold"}, 32'({s_bvalid, s_bresp}), 32'({1'b1, resp}));
        s_bready = 1'b1;
        @(posedge clk);
        #1;
        s_bready = 1'b0;
        @(negedge clk);
        chk({tag, "_bdone"}, 32'(s_bvalid), 32'd0);
    endtask

    task automatic get_r(input string tag, output logic [1:0] resp, output logic [31:0] rd);
        int n = 0;
        while (!s_rvalid && n < 50) begin
            @(negedge clk);
            n++;
        end
        resp = s_rresp;
        rd   = s_rdata;
        @(negedge clk);
        chk({tag, "_rhold"}, 32'({s_rvalid, s_rresp}), 32'({1'b1, resp}));
        chk({tag, "_rdhold"}, s_rdata, rd);
        s_rready = 1'b1;
        @(posedge clk);
        #1;
        s_rready = 1'b0;
        @(negedge clk);
        chk({tag, "_rdone"}, 32'(s_rvalid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed=running expected=done");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic        w;
        logic [11:0] a;
        logic [31:0] d;
        logic [31:0] rd;
        logic [1:0]  r;
        logic        seen;
        int          cyc;
        int          n;

        rst = 1'b0;
        s_awaddr = '0; s_awvalid = 1'b0; s_wdata = '0; s_wvalid = 1'b0; s_bready = 1'b0;
        s_araddr = '0; s_arvalid = 1'b0; s_rready = 1'b0;
        ready = 1'b0; rdata_in = '0; err_in = 1'b0;

        #3;
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_awready", 32'(s_awready), 32'd0);
        chk("rst_arready", 32'(s_arready), 32'd0);
        chk("rst_valids", 32'({s_bvalid, s_rvalid}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_readies", 32'({s_awready, s_wready, s_arready}), 32'b111);

        // write 0x200, ready two cycles late
        issue(1'b1, 32'h0000_0200, 32'hDEAD_BEEF, 1'b0, 32'h0);
        serve(2, 32'h0, 1'b0, w, a, d, cyc);
        chk("t1_sel_cycles", 32'(cyc), 32'd3);
        chk("t1_addr", 32'(a), 32'h200);
        chk("t1_wr", 32'(w), 32'd1);
        chk("t1_data", d, 32'hDEAD_BEEF);
        get_b("t1", r);
        chk("t1_bresp", 32'(r), 32'd0);

        // read 0x304
        issue(1'b0, 32'h0, 32'h0, 1'b1, 32'h0000_0304);
        serve(0, 32'h1234_5678, 1'b0, w, a, d, cyc);
        chk("t2_sel_cycles", 32'(cyc), 32'd1);
        chk("t2_addr", 32'(a), 32'h304);
        chk("t2_wr", 32'(w), 32'd0);
        chk("t2_data_out", d, 32'd0);
        get_r("t2", r, rd);
        chk("t2_rdata", rd, 32'h1234_5678);
        chk("t2_rresp", 32'(r), 32'd0);

        // read 0x100: below peripheral range
        issue(1'b0, 32'h0, 32'h0, 1'b1, 32'h0000_0100);
        seen = 1'b0;
        n = 0;
        while (!s_rvalid && n < 50) begin
            seen |= sel;
            @(negedge clk);
            n++;
        end
        get_r("t3", r, rd);
        chk("t3_sel_seen", 32'(seen), 32'd0);
        chk("t3_rresp", 32'(r), 32'd3);
        chk("t3_rdata", rd, 32'd0);

        // read 0x8F0: just above peripheral range
        issue(1'b0, 32'h0, 32'h0, 1'b1, 32'h0000_08F0);
        get_r("t3b", r, rd);
        chk("t3b_rresp", 32'(r), 32'd3);

        // stray ready pulse while idle
        @(negedge clk);
        ready = 1'b1; err_in = 1'b1; rdata_in = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        ready = 1'b0; err_in = 1'b0; rdata_in = '0;
        @(negedge clk);
        chk("t4_stray", 32'({sel, s_bvalid, s_rvalid, s_awready}), 32'b0001);

        // write 0x400, ready never comes
        issue(1'b1, 32'h0000_0400, 32'hCAFE_0000, 1'b0, 32'h0);
        n = 0;
        @(negedge clk);
        while (!sel && n < 50) begin
            @(negedge clk);
            n++;
        end
        cyc = 0;
        while (sel && cyc < 400) begin
            cyc++;
            @(negedge clk);
        end
        chk("t5_sel_cycles", 32'(cyc), 32'd255);
        get_b("t5", r);
        chk("t5_bresp", 32'(r), 32'd2);

        // minimum write latency, handshake cycle counted as the first
        issue(1'b1, 32'h0000_0204, 32'h0000_0001, 1'b0, 32'h0);
        n = 1;
        while (!s_bvalid && n < 20) begin
            @(negedge clk);
            ready = sel;
            if (!s_bvalid) n++;
        end
        ready = 1'b0;
        chk("t6_latency", 32'(n), 32'd4);
        get_b("t6", r);
        chk("t6_bresp", 32'(r), 32'd0);

        // write to top of range with downstream error
        issue(1'b1, 32'h0000_07FC, 32'h0000_00AA, 1'b0, 32'h0);
        serve(1, 32'h0, 1'b1, w, a, d, cyc);
        chk("t6b_addr", 32'(a), 32'h7FC);
        get_b("t6b", r);
        chk("t6b_bresp", 32'(r), 32'd2);

        // contested write 0x500 / read 0x600, round 1
        issue(1'b1, 32'h0000_0500, 32'h0000_0055, 1'b1, 32'h0000_0600);
        serve(0, 32'h0, 1'b0, w, a, d, cyc);
        chk("r1_first_wr", 32'(w), 32'd1);
        chk("r1_first_addr", 32'(a), 32'h500);
        get_b("r1", r);
        serve(0, 32'h0000_600D, 1'b0, w, a, d, cyc);
        chk("r1_second_wr", 32'(w), 32'd0);
        chk("r1_second_addr", 32'(a), 32'h600);
        get_r("r1", r, rd);
        chk("r1_rdata", rd, 32'h0000_600D);

        // round 2: read wins
        issue(1'b1, 32'h0000_0500, 32'h0000_0066, 1'b1, 32'h0000_0600);
        serve(0, 32'h0000_B00D, 1'b0, w, a, d, cyc);
        chk("r2_first_wr", 32'(w), 32'd0);
        chk("r2_first_addr", 32'(a), 32'h600);
        get_r("r2", r, rd);
        chk("r2_rdata", rd, 32'h0000_B00D);
        serve(0, 32'h0, 1'b0, w, a, d, cyc);
        chk("r2_second_wr", 32'(w), 32'd1);
        chk("r2_second_data", d, 32'h0000_0066);
        get_b("r2", r);
        chk("r2_bresp", 32'(r), 32'd0);

        // reset while in REQ
        issue(1'b1, 32'h0000_0300, 32'h0000_0011, 1'b0, 32'h0);
        n = 0;
        @(negedge clk);
        while (!sel && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("t8_in_req", 32'(sel), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("t8_sel_async", 32'(sel), 32'd0);
        chk("t8_ready_async", 32'({s_awready, s_wready, s_arready, s_bvalid}), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("t8_readies", 32'({s_awready, s_wready, s_arready}), 32'b111);
        issue(1'b0, 32'h0, 32'h0, 1'b1, 32'h0000_0700);
        serve(0, 32'hA5A5_5A5A, 1'b0, w, a, d, cyc);
        chk("t8_addr", 32'(a), 32'h700);
        chk("t8_wr", 32'(w), 32'd0);
        get_r("t8", r, rd);
        chk("t8_rdata", rd, 32'hA5A5_5A5A);
        chk("t8_rresp", 32'(r), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
